// File: rtl/spi_flash_slave_if.sv
// Pin-level bundle between the SPI master/memory side and the flash slave.
// The slave modport is the flash end; the master modport drives SPI pins and memory data.
interface spi_flash_slave_if #(
  parameter int ADDR_W = 24
);
  logic              spi_sck;
  logic              spi_ss;
  logic              spi_mosi;
  logic              spi_miso;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              cmd_err;

  modport slave (
    input  spi_sck, spi_ss, spi_mosi, mem_rdata,
    output spi_miso, mem_req, mem_addr, busy, cmd_err
  );

  modport master (
    output spi_sck, spi_ss, spi_mosi, mem_rdata,
    input  spi_miso, mem_req, mem_addr, busy, cmd_err
  );
endinterface

// File: rtl/spi_flash_slave.sv
// SPI NOR-flash slave answering the READ opcode from a byte-wide memory port.
// All SPI pins are oversampled in the system clock domain; miso streams with a one-byte prefetch.
module spi_flash_slave #(
  parameter int         ADDR_W   = 24,
  parameter logic [7:0] READ_CMD = 8'h03
) (
  input logic              clock,
  input logic              reset,
  spi_flash_slave_if.slave bus
);
  localparam int CNT_W = $clog2(ADDR_W);
  localparam int SH_W  = ADDR_W - 1;

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_IGNORE, ST_ADDR, ST_DATA} state_e;
  typedef enum logic [1:0] {TGT_NONE, TGT_TX, TGT_PF} tgt_e;

  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic ss_s1_q, ss_s2_q;
  logic mosi_s1_q, mosi_s2_q;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        pf_q, pf_d;
  logic [2:0]        out_cnt_q, out_cnt_d;
  logic              first_q, first_d;
  logic              miso_q, miso_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  tgt_e              req_tgt_q, req_tgt_d;
  tgt_e              rd_tgt_q, rd_tgt_d;
  logic              cmd_err_q, cmd_err_d;
  logic              busy_q, busy_d;

  logic              rise_s, fall_s;
  logic [7:0]        opcode_s;
  logic [ADDR_W-1:0] addr_s;

  assign rise_s   = sck_s2_q & ~sck_s3_q;
  assign fall_s   = ~sck_s2_q & sck_s3_q;
  assign opcode_s = {shift_q[6:0], mosi_s2_q};
  assign addr_s   = {shift_q, mosi_s2_q};

  // Two-flop synchronizers plus a third sck copy for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sck_s1_q  <= bus.spi_sck;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      ss_s1_q   <= bus.spi_ss;
      ss_s2_q   <= ss_s1_q;
      mosi_s1_q <= bus.spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  // Next-state and output decode; a deasserted ss overrides every strobe.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pf_d       = pf_q;
    out_cnt_d  = out_cnt_q;
    first_d    = first_q;
    miso_d     = miso_q;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    req_tgt_d  = TGT_NONE;
    rd_tgt_d   = req_tgt_q;
    cmd_err_d  = 1'b0;
    busy_d     = ~ss_s1_q;

    if (ss_s2_q) begin
      state_d   = ST_IDLE;
      miso_d    = 1'b1;
      bit_cnt_d = '0;
      out_cnt_d = 3'd0;
      first_d   = 1'b0;
      rd_tgt_d  = TGT_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
          miso_d    = 1'b1;
        end
        ST_CMD: begin
          miso_d = 1'b1;
          if (rise_s) begin
            shift_d = {shift_q[SH_W-2:0], mosi_s2_q};
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              if (opcode_s == READ_CMD) begin
                state_d = ST_ADDR;
              end else begin
                state_d   = ST_IGNORE;
                cmd_err_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ST_IGNORE: begin
          miso_d = 1'b1;
        end
        ST_ADDR: begin
          miso_d = 1'b1;
          if (rise_s) begin
            shift_d = {shift_q[SH_W-2:0], mosi_s2_q};
            if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
              bit_cnt_d  = '0;
              mem_req_d  = 1'b1;
              mem_addr_d = addr_s;
              req_tgt_d  = TGT_TX;
              state_d    = ST_DATA;
              first_d    = 1'b1;
              out_cnt_d  = 3'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ST_DATA: begin
          // The prefetch is issued one cycle after the first load so requests never abut.
          if (rd_tgt_q == TGT_TX) begin
            tx_d       = bus.mem_rdata;
            mem_req_d  = 1'b1;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            req_tgt_d  = TGT_PF;
          end else if (rd_tgt_q == TGT_PF) begin
            pf_d = bus.mem_rdata;
          end else begin
            pf_d = pf_q;
          end
          if (fall_s) begin
            out_cnt_d = out_cnt_q + 3'd1;
            if (first_q) begin
              first_d = 1'b0;
              miso_d  = tx_q[7];
            end else if (out_cnt_q == 3'd0) begin
              tx_d       = pf_q;
              miso_d     = pf_q[7];
              mem_req_d  = 1'b1;
              mem_addr_d = mem_addr_q + ADDR_W'(1);
              req_tgt_d  = TGT_PF;
            end else begin
              tx_d   = {tx_q[6:0], 1'b0};
              miso_d = tx_q[6];
            end
          end else begin
            out_cnt_d = out_cnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          miso_d  = 1'b1;
        end
      endcase
    end
  end

  // Protocol state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 8'h00;
      pf_q       <= 8'h00;
      out_cnt_q  <= 3'd0;
      first_q    <= 1'b0;
      miso_q     <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      req_tgt_q  <= TGT_NONE;
      rd_tgt_q   <= TGT_NONE;
      cmd_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      pf_q       <= pf_d;
      out_cnt_q  <= out_cnt_d;
      first_q    <= first_d;
      miso_q     <= miso_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      req_tgt_q  <= req_tgt_d;
      rd_tgt_q   <= rd_tgt_d;
      cmd_err_q  <= cmd_err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.spi_miso = miso_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.busy     = busy_q;
  assign bus.cmd_err  = cmd_err_q;
endmodule

// File: doc/spi_flash_slave.md
Name: spi_flash_slave

Overview:
- Synthesizable SPI NOR-flash slave. Sits directly downstream of the SPI master pins (spi_sck, spi_ss bit 0, spi_mosi, spi_miso).
- Decodes the 0x03 READ command and returns bytes from a simple byte-wide memory port. Used as the flash end of the XIP path in SoC simulation and FPGA builds.
- All SPI inputs are oversampled in the system clock domain. No SPI-clocked flops.

Parameters:
- ADDR_W, 24, flash byte-address width. Addresses wrap modulo 2^ADDR_W.
- READ_CMD, 8'h03, the only supported opcode.

Ports:
- clock  in  1  system clock. Must be at least 8x the spi_sck frequency.
- reset  in  1  asynchronous, active-low reset.
- spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_ss  in  1  chip select, active low.
- spi_mosi  in  1  master-out data, MSB first.
- spi_miso  out  1  slave-out data, MSB first. Idles high.
- mem_req  out  1  single-cycle read strobe.
- mem_addr  out  ADDR_W  byte address. Valid while mem_req=1.
- mem_rdata  in  8  read data. Valid exactly 1 clock after mem_req.
- busy  out  1  high while spi_ss is synchronized low.
- cmd_err  out  1  1-cycle pulse when an unsupported opcode completes.

Behaviour:
- Input synchronization
  - spi_sck, spi_ss and spi_mosi each pass through 2-flop synchronizers.
  - A third registered copy of sck gives rise (0->1) and fall (1->0) strobes.
  - spi_mosi is sampled on the synchronized value at the rise strobe.
- Reset (reset=0, asynchronous)
  - state=IDLE, spi_miso=1, mem_req=0, mem_addr=0, busy=0, cmd_err=0.
  - Shift registers and bit counters cleared. Synchronizer flops reset to sck=0, ss=1, mosi=0.
- spi_ss synchronized high, from any state
  - Next cycle: state=IDLE, spi_miso=1, counters cleared.
  - Any mem_req already issued completes harmlessly; its data is discarded.
  - Edges on sck while ss is high are ignored.
- IDLE: the falling edge of synchronized ss enters CMD with bit count 0.
- CMD: shift 8 bits on rise strobes.
  - On the 8th bit, if the opcode equals READ_CMD: go to ADDR.
  - Otherwise: go to IGNORE and pulse cmd_err for one cycle.
- IGNORE: spi_miso=1 until ss deasserts.
- ADDR: shift ADDR_W bits on rise strobes (24 bits, MSB first).
  - The cycle after the last bit: mem_req=1, mem_addr=the shifted address. Go to DATA.
- DATA
  - The cycle after mem_req, mem_rdata loads into the tx shift register.
  - At the same time a prefetch is issued: mem_req=1, mem_addr=address+1 (wrapping). The result is held in a prefetch byte register.
  - On the first fall strobe in DATA, spi_miso = tx[7]. Each later fall strobe shifts out the next bit.
  - After 8 fall strobes, on the fall strobe that would start the next byte:
    - tx loads from the prefetch register and spi_miso = its bit 7.
    - A new prefetch is issued for address+1.
  - The stream continues indefinitely until ss deasserts.
- Latency budget: the sck half-period must be ≥4 clocks (sync 2 + detect 1 + memory 1). The 8x clock ratio guarantees this.
- Address arithmetic: the address register is ADDR_W bits and increments modulo 2^ADDR_W, so 0xFFFFFF is followed by 0x000000.
- Simultaneous events:
  - A deassert of ss in the same cycle as a rise or fall strobe: the deassert wins and the strobe is ignored.
  - mem_req is never asserted in two consecutive cycles.
- Bits received after an opcode in IGNORE are discarded. There is no write path; mosi during DATA is ignored.
- busy equals the inverted synchronized ss.

Test Plan:
- READ at 0x000010, 32 data clocks, memory model returns addr[7:0]^8'h5A -> miso bytes 0x4A,0x4B,0x48,0x49. mem_addr sequence 0x10,0x11,0x12,0x13,0x14.
- Opcode 0x9F followed by 24 clocks -> cmd_err single pulse after the 8th rise. miso stays 1. No mem_req.
- ss deasserted after 12 address bits, then a full READ at 0x000000 -> the first transaction issues no mem_req. The second returns mem[0], mem[1] correctly.
- READ at 0xFFFFFF for 2 bytes -> mem_addr 0xFFFFFF then 0x000000. miso returns mem[0xFFFFFF] then mem[0x000000].
- reset pulled low mid-DATA -> spi_miso=1, mem_req=0, busy=0 within the same cycle (asynchronous). After release, the next READ works.
- sck toggled 16 times with ss high, then a READ at 0x000020 -> the toggles have no effect. Data matches mem[0x20].
